// File: rtl/mpa_rf_wb_arbiter.sv
// mpa_rf_wb_arbiter
// Write-back scheduler for the 32x32 register file. NREQ write-back units
// share the single write port (WE/A2/DIN) through a valid/ready handshake.
// A 32-entry busy scoreboard tracks reserved destinations so the issue stage
// can see RAW/WAW hazards.
// Build option: define MPA_RF_ARB_RR_EN for round-robin arbitration.
// Without it the arbiter is fixed priority (lowest index wins) and has no
// pointer register.
module mpa_rf_wb_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                CLK,
  input  logic                HW_RST,
  input  logic [NREQ-1:0]     REQ_VALID,
  input  logic [5*NREQ-1:0]   REQ_ADDR,
  input  logic [32*NREQ-1:0]  REQ_DATA,
  output logic [NREQ-1:0]     REQ_READY,
  input  logic                RSV_VALID,
  input  logic [4:0]          RSV_ADDR,
  output logic                RSV_READY,
  input  logic [4:0]          RD_ADDR0,
  input  logic [4:0]          RD_ADDR1,
  output logic                HAZ0,
  output logic                HAZ1,
  output logic                WE,
  output logic [4:0]          A2,
  output logic [31:0]         DIN,
  output logic [31:0]         BUSY
);

  logic [NREQ-1:0] w_grant;
  logic            w_xfer;
  logic            w_wrValid;
  logic [4:0]      w_selAddr;
  logic [31:0]     w_selData;
  logic            w_rsvAcc;
  logic [31:0]     w_busyNext;

  logic            r_we;
  logic [4:0]      r_a2;
  logic [31:0]     r_din;
  logic [31:0]     r_busy;

`ifdef MPA_RF_ARB_RR_EN
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptrNext;

  // Round-robin grant: first valid requester at or after the pointer wins
  always_comb begin
    logic [PW-1:0] idx;
    logic          found;
    w_grant   = '0;
    w_ptrNext = r_ptr;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = PW'((int'(r_ptr) + k) % NREQ);
      if (!found && REQ_VALID[idx]) begin
        w_grant[idx] = 1'b1;
        w_ptrNext    = (int'(idx) == NREQ - 1) ? '0 : idx + PW'(1);
        found        = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner only when a transfer actually happens
  always_ff @(posedge CLK) begin
    if (HW_RST) begin
      r_ptr <= '0;
    end else if (w_xfer) begin
      r_ptr <= w_ptrNext;
    end
  end
`else
  // Fixed priority: isolate the lowest set request bit
  always_comb begin
    w_grant = REQ_VALID & (~REQ_VALID + NREQ'(1));
  end
`endif

  assign REQ_READY = w_grant;
  assign w_xfer    = |w_grant;

  // Route the winning requester's address and data toward the write port
  always_comb begin
    w_selAddr = '0;
    w_selData = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_selAddr = REQ_ADDR[5*i +: 5];
        w_selData = REQ_DATA[32*i +: 32];
      end
    end
  end

  // Writes to $zero finish the handshake but never reach the register file
  assign w_wrValid = w_xfer && (w_selAddr != 5'd0);

  // A busy destination blocks a new reservation until its write-back lands
  assign w_rsvAcc  = RSV_VALID && ((RSV_ADDR == 5'd0) || !r_busy[RSV_ADDR]);
  assign RSV_READY = w_rsvAcc;

  // Scoreboard update: clear on write-back, set on accepted reservation
  always_comb begin
    w_busyNext = r_busy;
    if (w_wrValid) begin
      w_busyNext[w_selAddr] = 1'b0;
    end
    if (w_rsvAcc && (RSV_ADDR != 5'd0)) begin
      w_busyNext[RSV_ADDR] = 1'b1;
    end
  end

  // Register-file write port and scoreboard state, one cycle after transfer
  always_ff @(posedge CLK) begin
    if (HW_RST) begin
      r_we   <= 1'b0;
      r_a2   <= '0;
      r_din  <= '0;
      r_busy <= '0;
    end else begin
      r_we   <= w_wrValid;
      r_busy <= w_busyNext;
      if (w_wrValid) begin
        r_a2  <= w_selAddr;
        r_din <= w_selData;
      end
    end
  end

  // Hazards read the live scoreboard; $zero never carries a hazard
  always_comb begin
    HAZ0 = (RD_ADDR0 != 5'd0) && r_busy[RD_ADDR0];
    HAZ1 = (RD_ADDR1 != 5'd0) && r_busy[RD_ADDR1];
  end

  assign WE   = r_we;
  assign A2   = r_a2;
  assign DIN  = r_din;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_mpa_rf_wb_arbiter.sv
// tb_mpa_rf_wb_arbiter
// Self-checking bench for mpa_rf_wb_arbiter. Directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the
// scoreboard, arbiter and write port. Follows MPA_RF_ARB_RR_EN like the RTL.
module tb_mpa_rf_wb_arbiter;

  localparam int NREQ = 3;

  logic                CLK = 1'b0;
  logic                HW_RST;
  logic [NREQ-1:0]     REQ_VALID;
  logic [5*NREQ-1:0]   REQ_ADDR;
  logic [32*NREQ-1:0]  REQ_DATA;
  logic [NREQ-1:0]     REQ_READY;
  logic                RSV_VALID;
  logic [4:0]          RSV_ADDR;
  logic                RSV_READY;
  logic [4:0]          RD_ADDR0;
  logic [4:0]          RD_ADDR1;
  logic                HAZ0;
  logic                HAZ1;
  logic                WE;
  logic [4:0]          A2;
  logic [31:0]         DIN;
  logic [31:0]         BUSY;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mBusy;
  logic        mWe;
  logic [4:0]  mA2;
  logic [31:0] mDin;
  logic        mA2Known;
  int          mPtr;

  // Requester side: each unit holds its request until it is granted
  logic        pend[NREQ];
  logic [4:0]  pendAddr[NREQ];
  logic [31:0] pendData[NREQ];

  mpa_rf_wb_arbiter #(.NREQ(NREQ)) dut (
    .CLK       (CLK),
    .HW_RST    (HW_RST),
    .REQ_VALID (REQ_VALID),
    .REQ_ADDR  (REQ_ADDR),
    .REQ_DATA  (REQ_DATA),
    .REQ_READY (REQ_READY),
    .RSV_VALID (RSV_VALID),
    .RSV_ADDR  (RSV_ADDR),
    .RSV_READY (RSV_READY),
    .RD_ADDR0  (RD_ADDR0),
    .RD_ADDR1  (RD_ADDR1),
    .HAZ0      (HAZ0),
    .HAZ1      (HAZ1),
    .WE        (WE),
    .A2        (A2),
    .DIN       (DIN),
    .BUSY      (BUSY)
  );

  // Free-running clock, 10 time units per period
  always #5 CLK = ~CLK;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Which requester should win, from the arbitration policy alone
  function automatic int expGrant();
    int w;
    w = -1;
`ifdef MPA_RF_ARB_RR_EN
    for (int k = 0; k < NREQ; k++) begin
      if (w < 0 && pend[(mPtr + k) % NREQ]) w = (mPtr + k) % NREQ;
    end
`else
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (pend[i]) w = i;
    end
`endif
    return w;
  endfunction

  function automatic logic isBusy(input logic [4:0] a);
    return (a != 5'd0) && mBusy[a];
  endfunction

  task automatic modelReset();
    mBusy    = '0;
    mWe      = 1'b0;
    mA2      = '0;
    mDin     = '0;
    mA2Known = 1'b1;
    mPtr     = 0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
  endtask

  // One clock cycle: drive requesters, compare everything, advance model
  task automatic cycle();
    int              g;
    logic [NREQ-1:0] gv;
    logic            rsvOk;
    for (int i = 0; i < NREQ; i++) begin
      REQ_VALID[i]        = pend[i];
      REQ_ADDR[5*i +: 5]  = pendAddr[i];
      REQ_DATA[32*i +: 32] = pendData[i];
    end
    #1;
    g  = expGrant();
    gv = '0;
    if (g >= 0) gv[g] = 1'b1;
    rsvOk = RSV_VALID && ((RSV_ADDR == 5'd0) || !mBusy[RSV_ADDR]);
    checkOutput("req_ready", 32'(REQ_READY), 32'(gv));
    checkOutput("rsv_ready", 32'(RSV_READY), 32'(rsvOk));
    checkOutput("haz0", 32'(HAZ0), 32'(isBusy(RD_ADDR0)));
    checkOutput("haz1", 32'(HAZ1), 32'(isBusy(RD_ADDR1)));
    checkOutput("we", 32'(WE), 32'(mWe));
    checkOutput("busy", BUSY, mBusy);
    if (mA2Known) begin
      checkOutput("a2", 32'(A2), 32'(mA2));
      checkOutput("din", DIN, mDin);
    end
    if (HW_RST) begin
      modelReset();
    end else begin
      mWe = 1'b0;
      if (g >= 0) begin
        pend[g] = 1'b0;
        mPtr    = (g + 1) % NREQ;
        if (pendAddr[g] != 5'd0) begin
          mWe      = 1'b1;
          mA2      = pendAddr[g];
          mDin     = pendData[g];
          mA2Known = 1'b1;
          mBusy[pendAddr[g]] = 1'b0;
        end else begin
          mA2Known = 1'b0;
        end
      end
      if (rsvOk && RSV_ADDR != 5'd0) mBusy[RSV_ADDR] = 1'b1;
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // Prefer registers that are currently reserved so writes retire them
  function automatic logic [4:0] pickAddr();
    logic [4:0] a;
    a = 5'($urandom_range(31));
    if ($urandom_range(1) == 1) begin
      for (int t = 0; t < 8; t++) begin
        if (!mBusy[a]) a = 5'($urandom_range(31));
      end
    end
    return a;
  endfunction

  // Random traffic that obeys the requester and reservation protocol
  task automatic applyStimulus();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && $urandom_range(2) == 0) begin
        pend[i]     = 1'b1;
        pendAddr[i] = pickAddr();
        pendData[i] = $urandom();
      end
    end
    RSV_VALID = 1'($urandom_range(1));
    RSV_ADDR  = 5'($urandom_range(31));
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i] && RSV_ADDR != 5'd0 && pendAddr[i] == RSV_ADDR) RSV_VALID = 1'b0;
    end
    RD_ADDR0 = pickAddr();
    RD_ADDR1 = pickAddr();
    HW_RST   = ($urandom_range(99) == 0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i]     = 1'b0;
      pendAddr[i] = '0;
      pendData[i] = '0;
    end

    // Reset for two cycles while every input is active
    HW_RST    = 1'b1;
    REQ_VALID = '1;
    REQ_ADDR  = '1;
    REQ_DATA  = '1;
    RSV_VALID = 1'b1;
    RSV_ADDR  = 5'd7;
    RD_ADDR0  = 5'd7;
    RD_ADDR1  = 5'd7;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    modelReset();
    HW_RST    = 1'b0;
    RSV_VALID = 1'b0;
    cycle();
    checkOutput("rst_busy", BUSY, 32'h0);

    // Reserve r5
    RSV_VALID = 1'b1; RSV_ADDR = 5'd5;
    cycle();
    RSV_VALID = 1'b0;
    checkOutput("busy_r5", BUSY, 32'h0000_0020);

    // Single write-back to r8 from requester 1
    RSV_VALID = 1'b1; RSV_ADDR = 5'd8;
    cycle();
    RSV_VALID = 1'b0;
    pend[1] = 1'b1; pendAddr[1] = 5'd8; pendData[1] = 32'hDEAD_BEEF;
    RD_ADDR0 = 5'd8;
    cycle();
    checkOutput("wb_we", 32'(WE), 32'd1);
    checkOutput("wb_a2", 32'(A2), 32'd8);
    checkOutput("wb_din", DIN, 32'hDEAD_BEEF);
    checkOutput("wb_haz0_drop", 32'(HAZ0), 32'd0);
    cycle();

    // Three requesters contend for the port
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b1; pendAddr[i] = 5'(10 + i); pendData[i] = $urandom();
    end
    repeat (4) cycle();

    // WAW stall on r3
    RSV_VALID = 1'b1; RSV_ADDR = 5'd3;
    cycle();
    repeat (2) cycle();
    pend[0] = 1'b1; pendAddr[0] = 5'd3; pendData[0] = 32'h0000_0333;
    cycle();
    cycle();
    RSV_VALID = 1'b0;
    pend[0] = 1'b1; pendAddr[0] = 5'd3; pendData[0] = 32'h0000_0334;
    cycle();

    // $zero reservation and write
    RSV_VALID = 1'b1; RSV_ADDR = 5'd0; RD_ADDR0 = 5'd0;
    cycle();
    RSV_VALID = 1'b0;
    pend[0] = 1'b1; pendAddr[0] = 5'd0; pendData[0] = 32'h0000_1234;
    cycle();
    cycle();
    checkOutput("zero_we", 32'(WE), 32'd0);

    // Reset while r4/r9 are busy and requester 2 is pending
    RSV_VALID = 1'b1; RSV_ADDR = 5'd4;
    cycle();
    RSV_ADDR = 5'd9;
    cycle();
    RSV_VALID = 1'b0;
    pend[2] = 1'b1; pendAddr[2] = 5'd9; pendData[2] = 32'h0000_0999;
    HW_RST = 1'b1;
    cycle();
    HW_RST = 1'b0;
    cycle();
    checkOutput("rstmid_busy", BUSY, 32'h0);
    checkOutput("rstmid_we", 32'(WE), 32'd0);

    // Randomized traffic
    repeat (3000) begin
      applyStimulus();
      cycle();
    end
    HW_RST = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
